// File: rtl/hammer_sweep_if.sv
// Operand/response/result bundle between hammer_sweep and the expression under test.
// The master side drives start/mode/y_in; the slave side is the sweep engine.
interface hammer_sweep_if #(
    parameter int A_WIDTH   = 4,
    parameter int B_WIDTH   = 4,
    parameter int Y_WIDTH   = 8,
    parameter int SIG_WIDTH = 32
);
    logic                       start;
    logic                       mode;
    logic [A_WIDTH-1:0]         a;
    logic [B_WIDTH-1:0]         b;
    logic [Y_WIDTH-1:0]         y_in;
    logic                       busy;
    logic                       done;
    logic [SIG_WIDTH-1:0]       signature;
    logic [A_WIDTH+B_WIDTH:0]   vec_count;
    logic                       x_seen;

    modport master (
        output start, mode, y_in,
        input  a, b, busy, done, signature, vec_count, x_seen
    );

    modport slave (
        input  start, mode, y_in,
        output a, b, busy, done, signature, vec_count, x_seen
    );
endinterface

// File: rtl/hammer_sweep.sv
// Stimulus sweep (exhaustive or corner) with MISR compaction of the response.
// Optional x/z screening of y_in is enabled by defining HAMMER_SWEEP_XCHK_EN.
module hammer_sweep #(
    parameter int                   A_WIDTH   = 4,
    parameter int                   B_WIDTH   = 4,
    parameter int                   Y_WIDTH   = 8,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7,
    parameter logic [SIG_WIDTH-1:0] SEED      = '1
) (
    input logic          clk,
    input logic          rst_n,
    hammer_sweep_if.slave bus
);
    localparam int CW = A_WIDTH + B_WIDTH + 1;
    localparam int VW = A_WIDTH + B_WIDTH;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic [2:0]           ia_q, ia_d, ib_q, ib_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [Y_WIDTH-1:0]   y_clean;
    logic                 last_vec;
    logic                 busy_o, done_o;

    function automatic logic [SIG_WIDTH-1:0] misr_step(input logic [SIG_WIDTH-1:0] s,
                                                       input logic [Y_WIDTH-1:0]   y);
        logic [SIG_WIDTH-1:0] yext;
        yext = '0;
        yext[Y_WIDTH-1:0] = y;
        return {s[SIG_WIDTH-2:0], 1'b0} ^ (s[SIG_WIDTH-1] ? POLY : '0) ^ yext;
    endfunction

    // Corner list: 0, 1, all-ones, MSB-only, all-ones-except-MSB (truncated to width).
    function automatic logic [A_WIDTH-1:0] corner_a(input logic [2:0] i);
        logic [A_WIDTH-1:0] msb;
        logic [A_WIDTH-1:0] one;
        msb = '0;
        msb[A_WIDTH-1] = 1'b1;
        one = '0;
        one[0] = 1'b1;
        case (i)
            3'd0:    return '0;
            3'd1:    return one;
            3'd2:    return '1;
            3'd3:    return msb;
            default: return ~msb;
        endcase
    endfunction

    function automatic logic [B_WIDTH-1:0] corner_b(input logic [2:0] i);
        logic [B_WIDTH-1:0] msb;
        logic [B_WIDTH-1:0] one;
        msb = '0;
        msb[B_WIDTH-1] = 1'b1;
        one = '0;
        one[0] = 1'b1;
        case (i)
            3'd0:    return '0;
            3'd1:    return one;
            3'd2:    return '1;
            3'd3:    return msb;
            default: return ~msb;
        endcase
    endfunction

    assign last_vec = mode_q ? ((ia_q == 3'd4) && (ib_q == 3'd4)) : (&{b_q, a_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SWEEP;
            SWEEP:   if (last_vec)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == SWEEP);
        done_o = (state_q == DONE);
    end

    always_comb begin
        mode_d = mode_q;
        a_d    = a_q;
        b_d    = b_q;
        ia_d   = ia_q;
        ib_d   = ib_q;
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        if ((state_q == IDLE) && bus.start) begin
            mode_d = bus.mode;
            a_d    = '0;
            b_d    = '0;
            ia_d   = 3'd0;
            ib_d   = 3'd0;
            sig_d  = SEED;
            cnt_d  = '0;
        end else if (state_q == SWEEP) begin
            sig_d = misr_step(sig_q, y_clean);
            cnt_d = cnt_q + CW'(1);
            // On the last vector the operands are left holding it.
            if (!last_vec) begin
                if (mode_q) begin
                    if (ia_q == 3'd4) begin
                        ia_d = 3'd0;
                        ib_d = ib_q + 3'd1;
                    end else begin
                        ia_d = ia_q + 3'd1;
                    end
                    a_d = corner_a(ia_d);
                    b_d = corner_b(ib_d);
                end else begin
                    {b_d, a_d} = {b_q, a_q} + VW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            ia_q   <= 3'd0;
            ib_q   <= 3'd0;
            sig_q  <= '0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            a_q    <= a_d;
            b_q    <= b_d;
            ia_q   <= ia_d;
            ib_q   <= ib_d;
            sig_q  <= sig_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef HAMMER_SWEEP_XCHK_EN
    logic y_unknown;
    logic x_q, x_d;

    // Unknown bits fold as 0 so the signature itself never goes x.
    always_comb begin
        y_clean = '0;
        for (int i = 0; i < Y_WIDTH; i++) begin
            y_clean[i] = (bus.y_in[i] === 1'b1);
        end
        y_unknown = ((^bus.y_in) === 1'bx);
    end

    always_comb begin
        x_d = x_q;
        if ((state_q == IDLE) && bus.start) begin
            x_d = 1'b0;
        end else if (state_q == SWEEP) begin
            x_d = x_q | y_unknown;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= 1'b0;
        end else begin
            x_q <= x_d;
        end
    end

    assign bus.x_seen = x_q;
`else
    assign y_clean    = bus.y_in;
    assign bus.x_seen = 1'b0;
`endif

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.signature = sig_q;
    assign bus.vec_count = cnt_q;
endmodule
